// File: rtl/seq_mul.sv
`default_nettype none
// ============================================================================
// Module      : seq_mul
// Description : Radix-2 shift-add sequential multiplier. One multiplier bit
//               is consumed per clock. Unsigned and two's-complement operands
//               are supported. Signed operands are multiplied as magnitudes,
//               and the product is negated at the end when the sign flag is set.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mul #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   M,
    output logic                 busy,
    output logic                 done
);

    localparam int              C_PW   = 2 * WIDTH;
    localparam int              C_CW   = $clog2(WIDTH + 1);
    localparam logic [C_CW-1:0] C_LAST = C_CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q,  state_d;
    logic [C_PW-1:0]   mcand_q,  mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [C_PW-1:0]   acc_q,    acc_d;
    logic [C_CW-1:0]   cnt_q,    cnt_d;
    logic              sign_q,   sign_d;
    logic [C_PW-1:0]   m_q,      m_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;

    logic [WIDTH-1:0]  w_mag_a;
    logic [WIDTH-1:0]  w_mag_b;
    logic [C_PW-1:0]   w_acc_sum;

    // Operand magnitudes and the accumulator value after this step's add.
    // Negating the most-negative value wraps to 2^(WIDTH-1), which is exactly
    // the required magnitude when the result is read as unsigned.
    always_comb begin
        w_mag_a   = (signed_mode && A[WIDTH-1]) ? (~A + WIDTH'(1)) : A;
        w_mag_b   = (signed_mode && B[WIDTH-1]) ? (~B + WIDTH'(1)) : B;
        w_acc_sum = acc_q + (mplier_q[0] ? mcand_q : {C_PW{1'b0}});
    end

    // Next-state logic: operand capture, the shift-add step and the result load.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        m_d      = m_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                // DONE accepts start as well, so back-to-back operations need no idle cycle.
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, w_mag_a};
                    mplier_d = w_mag_b;
                    acc_d    = {C_PW{1'b0}};
                    cnt_d    = {C_CW{1'b0}};
                    sign_d   = signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
                    state_d  = RUN;
                    busy_d   = 1'b1;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                // start is ignored here; the operation runs to completion.
                acc_d    = w_acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + C_CW'(1);
                if (cnt_q == C_LAST) begin
                    m_d     = sign_q ? (~w_acc_sum + C_PW'(1)) : w_acc_sum;
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= {C_PW{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            acc_q    <= {C_PW{1'b0}};
            cnt_q    <= {C_CW{1'b0}};
            sign_q   <= 1'b0;
            m_q      <= {C_PW{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            m_q      <= m_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign M    = m_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_mul.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_mul
// Description : Self-checking bench for seq_mul. It runs a WIDTH=4 instance
//               and a WIDTH=8 instance against an arithmetic timeline model,
//               and uses directed vectors with literal expected products.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_mul;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_i [2];
    logic       sm_i    [2];
    logic [7:0] a_i     [2];
    logic [7:0] b_i     [2];

    logic [7:0]  m4;
    logic [15:0] m8;
    logic        busy4, done4, busy8, done8;

    logic [15:0] m_o    [2];
    logic        busy_o [2];
    logic        done_o [2];

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    seq_mul #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start_i[0]), .signed_mode(sm_i[0]),
        .A(a_i[0][3:0]), .B(b_i[0][3:0]), .M(m4), .busy(busy4), .done(done4)
    );

    seq_mul #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start_i[1]), .signed_mode(sm_i[1]),
        .A(a_i[1]), .B(b_i[1]), .M(m8), .busy(busy8), .done(done8)
    );

    always_comb begin
        m_o[0]    = {8'h00, m4};
        m_o[1]    = m8;
        busy_o[0] = busy4;
        busy_o[1] = busy8;
        done_o[0] = done4;
        done_o[1] = done8;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference product computed with plain integer arithmetic.
    function automatic logic [15:0] ref_prod(input int w, input logic [7:0] a,
                                             input logic [7:0] b, input logic s);
        longint mask, sa, sb, p;
        mask = (longint'(1) << w) - 1;
        sa   = longint'(a) & mask;
        sb   = longint'(b) & mask;
        if (s) begin
            if (sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
            if (sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
        end
        p = sa * sb;
        return 16'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    // Timeline model: an accepted start produces its product exactly W edges later.
    // A start is accepted only when no operation is outstanding.
    int          rem     [2] = '{0, 0};
    logic [15:0] pend    [2] = '{16'h0, 16'h0};
    logic [15:0] exp_m   [2] = '{16'h0, 16'h0};
    bit          exp_busy[2] = '{1'b0, 1'b0};
    bit          exp_done[2] = '{1'b0, 1'b0};

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                rem[k]      = 0;
                exp_m[k]    = 16'h0;
                exp_done[k] = 1'b0;
            end else begin
                exp_done[k] = 1'b0;
                if (rem[k] > 0) begin
                    rem[k]--;
                    if (rem[k] == 0) begin
                        exp_m[k]    = pend[k];
                        exp_done[k] = 1'b1;
                    end
                end else if (start_i[k]) begin
                    rem[k]  = (k == 0) ? 4 : 8;
                    pend[k] = ref_prod((k == 0) ? 4 : 8, a_i[k], b_i[k], sm_i[k]);
                end
            end
            exp_busy[k] = (rem[k] > 0);
        end
    end

    // Compare outputs against the model every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("cmp_busy_w%0d", (k == 0) ? 4 : 8), 64'(busy_o[k]), 64'(exp_busy[k]));
                check($sformatf("cmp_done_w%0d", (k == 0) ? 4 : 8), 64'(done_o[k]), 64'(exp_done[k]));
                check($sformatf("cmp_m_w%0d",    (k == 0) ? 4 : 8), 64'(m_o[k]),    64'(exp_m[k]));
            end
        end
    end

    // Launch one operation and check latency, busy length and the literal result.
    task automatic run_op(input int k, input logic [7:0] a, input logic [7:0] b,
                          input logic s, input logic [15:0] lit);
        int w;
        int cyc;
        int busy_cnt;
        w = (k == 0) ? 4 : 8;
        a_i[k] = a; b_i[k] = b; sm_i[k] = s; start_i[k] = 1'b1;
        @(negedge clk);
        start_i[k] = 1'b0;
        cyc = 0;
        busy_cnt = busy_o[k] ? 1 : 0;
        while (!done_o[k] && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busy_o[k]) busy_cnt++;
        end
        check($sformatf("latency_w%0d_%0h_%0h", w, a, b), 64'(cyc), 64'(w));
        check($sformatf("busy_len_w%0d_%0h_%0h", w, a, b), 64'(busy_cnt), 64'(w));
        check($sformatf("result_w%0d_%0h_%0h_s%0d", w, a, b, s), 64'(m_o[k]), 64'(lit));
        check($sformatf("model_pin_w%0d_%0h_%0h", w, a, b), 64'(exp_m[k]), 64'(lit));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        int first_d;
        int last_d;
        logic [7:0] ra;
        logic [7:0] rb;

        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start_i[k] = 1'b0; sm_i[k] = 1'b0; a_i[k] = 8'h0; b_i[k] = 8'h0;
        end
        repeat (2) @(negedge clk);
        check("reset_m",    64'(m4),    64'h0);
        check("reset_busy", 64'(busy4), 64'h0);
        check("reset_done", 64'(done4), 64'h0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Unsigned sweep, WIDTH=4
        run_op(0, 8'd0,  8'd4,  1'b0, 16'h00);
        run_op(0, 8'd12, 8'd8,  1'b0, 16'h60);
        run_op(0, 8'd6,  8'd5,  1'b0, 16'h1E);
        run_op(0, 8'd15, 8'd10, 1'b0, 16'h96);
        run_op(0, 8'd7,  8'd8,  1'b0, 16'h38);
        run_op(0, 8'd15, 8'd15, 1'b0, 16'hE1);

        // Signed, WIDTH=4
        run_op(0, 8'hF, 8'hF, 1'b1, 16'h01);
        run_op(0, 8'h8, 8'h7, 1'b1, 16'hC8);
        run_op(0, 8'h8, 8'h8, 1'b1, 16'h40);
        run_op(0, 8'h3, 8'hE, 1'b1, 16'hFA);
        run_op(0, 8'h0, 8'hF, 1'b1, 16'h00);

        // Back-to-back with start held high
        @(negedge clk);
        a_i[0] = 8'd6; b_i[0] = 8'd5; sm_i[0] = 1'b0; start_i[0] = 1'b1;
        ndone = 0; first_d = 0; last_d = 0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (done4) begin
                ndone++;
                if (ndone == 1) first_d = i;
                last_d = i;
                check("b2b_m", 64'(m4), 64'h1E);
            end
        end
        start_i[0] = 1'b0;
        check("b2b_count",  64'(ndone), 64'd3);
        check("b2b_period", 64'(last_d - first_d), 64'd10);
        repeat (6) @(negedge clk);

        // start during RUN is ignored
        a_i[0] = 8'd12; b_i[0] = 8'd8; sm_i[0] = 1'b0; start_i[0] = 1'b1;
        @(negedge clk);
        start_i[0] = 1'b0;
        @(negedge clk);
        a_i[0] = 8'd15; b_i[0] = 8'd15; start_i[0] = 1'b1;
        @(negedge clk);
        start_i[0] = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done4) begin
                ndone++;
                check("ign_m", 64'(m4), 64'h60);
            end
        end
        check("ign_done_count", 64'(ndone), 64'd1);

        // Reset two cycles into RUN
        a_i[0] = 8'd15; b_i[0] = 8'd15; sm_i[0] = 1'b0; start_i[0] = 1'b1;
        @(negedge clk);
        start_i[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_m",    64'(m4),    64'h0);
        check("rst_mid_busy", 64'(busy4), 64'h0);
        check("rst_mid_done", 64'(done4), 64'h0);
        rst_n = 1'b1;
        run_op(0, 8'd9, 8'd9, 1'b0, 16'h51);

        // WIDTH=8 corners
        run_op(1, 8'hFF, 8'hFF, 1'b0, 16'hFE01);
        run_op(1, 8'h80, 8'h80, 1'b1, 16'h4000);
        run_op(1, 8'h80, 8'h7F, 1'b1, 16'hC080);
        run_op(1, 8'h00, 8'h80, 1'b1, 16'h0000);
        run_op(1, 8'hFF, 8'h02, 1'b1, 16'hFFFE);

        // WIDTH=8 random pairs in both modes
        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run_op(1, ra, rb, 1'(i & 1), ref_prod(8, ra, rb, 1'(i & 1)));
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
